// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game controller.
package simon_pkg;

    // Width of one displayed / entered symbol (four buttons).
    localparam int unsigned SymW  = 2;
    // Width of the level output.
    localparam int unsigned LvlW  = 6;
    // Sequence generator width, seed and feedback taps (x^8 + x^6 + x^5 + x^4 + 1).
    localparam int unsigned LfsrW = 8;
    localparam logic [LfsrW-1:0] LfsrSeed = 8'hA5;
    localparam logic [LfsrW-1:0] LfsrTaps = 8'b1011_1000;

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StShowOn,
        StShowOff,
        StListen,
        StLost,
        StWon
    } state_e;

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; a nonzero seed keeps it off the all-zero lock-up state.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic [LfsrW-1:0] q
);

    logic [LfsrW-1:0] r_q;
    logic             w_fb;

    assign w_fb = ^(r_q & LfsrTaps);
    assign q    = r_q;

    // Shift every clock so the captured symbols depend on when the player hits start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= LfsrSeed;
        end else begin
            r_q <= {r_q[LfsrW-2:0], w_fb};
        end
    end

endmodule

// File: rtl/simon_game_ctrl.sv
// Simon game controller: grows a random symbol sequence, plays it back and checks the player.
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned ON_TICKS      = 4,
    parameter int unsigned OFF_TICKS     = 2,
    parameter int unsigned TIMEOUT_TICKS = 20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            start,
    input  logic            player_pressed,
    input  logic [SymW-1:0] player_num,
    output logic            simon_turn,
    output logic [SymW-1:0] simon_num,
    output logic            simon_pressed,
    output logic [LvlW-1:0] level,
    output logic            game_over,
    output logic            win
);

    localparam int unsigned IdxW     = $clog2(MAX_LEN);
    localparam int unsigned MaxOnOff = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MaxTicks = (TIMEOUT_TICKS > MaxOnOff) ? TIMEOUT_TICKS : MaxOnOff;
    localparam int unsigned CntW     = $clog2(MaxTicks + 1);

    localparam logic [CntW-1:0] OnLast  = CntW'(ON_TICKS - 1);
    localparam logic [CntW-1:0] OffLast = CntW'(OFF_TICKS - 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_TICKS - 1);
    localparam logic [LvlW-1:0] MaxLvl  = LvlW'(MAX_LEN);

    state_e          r_state, w_state_d;
    logic [LvlW-1:0] r_level, w_level_d;
    logic [IdxW-1:0] r_idx, w_idx_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            r_game_over, w_game_over_d;
    logic            r_win, w_win_d;
    logic            w_seq_we;
    logic [SymW-1:0] r_seq [MAX_LEN];

    logic [LfsrW-1:0] w_lfsr;
    logic             w_unused_lfsr;
    logic [SymW-1:0]  w_sym;
    logic             w_last;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    // Only the low bits feed the sequence.
    assign w_unused_lfsr = ^w_lfsr[LfsrW-1:SymW];

    assign w_sym  = r_seq[r_idx];
    assign w_last = ({{(LvlW - IdxW){1'b0}}, r_idx} == (r_level - LvlW'(1)));

    assign level     = r_level;
    assign game_over = r_game_over;
    assign win       = r_win;

    // State and counter registers; reset aborts any display or check in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_level     <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_level     <= w_level_d;
            r_idx       <= w_idx_d;
            r_cnt       <= w_cnt_d;
            r_game_over <= w_game_over_d;
            r_win       <= w_win_d;
        end
    end

    // Sequence store; entries at or above the current level are never read.
    always_ff @(posedge clk) begin
        if (w_seq_we) begin
            r_seq[r_level[IdxW-1:0]] <= w_lfsr[SymW-1:0];
        end
    end

    // Next-state logic; start restarts the game from any state.
    always_comb begin
        w_state_d     = r_state;
        w_level_d     = r_level;
        w_idx_d       = r_idx;
        w_cnt_d       = r_cnt;
        w_game_over_d = r_game_over;
        w_win_d       = r_win;
        w_seq_we      = 1'b0;

        if (start) begin
            w_state_d     = StAdd;
            w_level_d     = '0;
            w_idx_d       = '0;
            w_cnt_d       = '0;
            w_game_over_d = 1'b0;
            w_win_d       = 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StLost, StWon: begin
                end
                StAdd: begin
                    w_seq_we  = 1'b1;
                    w_level_d = r_level + LvlW'(1);
                    w_idx_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = StShowOn;
                end
                StShowOn: begin
                    if (tick) begin
                        if (r_cnt == OnLast) begin
                            w_cnt_d   = '0;
                            w_state_d = StShowOff;
                        end else begin
                            w_cnt_d = r_cnt + CntW'(1);
                        end
                    end
                end
                StShowOff: begin
                    if (tick) begin
                        if (r_cnt == OffLast) begin
                            w_cnt_d = '0;
                            if (w_last) begin
                                w_idx_d   = '0;
                                w_state_d = StListen;
                            end else begin
                                w_idx_d   = r_idx + IdxW'(1);
                                w_state_d = StShowOn;
                            end
                        end else begin
                            w_cnt_d = r_cnt + CntW'(1);
                        end
                    end
                end
                StListen: begin
                    // A press wins over a coincident final timeout tick.
                    if (player_pressed) begin
                        w_cnt_d = '0;
                        if (player_num != w_sym) begin
                            w_state_d     = StLost;
                            w_game_over_d = 1'b1;
                        end else if (w_last) begin
                            if (r_level == MaxLvl) begin
                                w_state_d = StWon;
                                w_win_d   = 1'b1;
                            end else begin
                                w_state_d = StAdd;
                            end
                        end else begin
                            w_idx_d = r_idx + IdxW'(1);
                        end
                    end else if (tick) begin
                        if (r_cnt == ToLast) begin
                            w_cnt_d       = '0;
                            w_state_d     = StLost;
                            w_game_over_d = 1'b1;
                        end else begin
                            w_cnt_d = r_cnt + CntW'(1);
                        end
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // Display outputs decoded from the current state.
    always_comb begin
        simon_turn    = 1'b0;
        simon_pressed = 1'b0;
        simon_num     = '0;
        case (r_state)
            StAdd, StShowOff: begin
                simon_turn = 1'b1;
            end
            StShowOn: begin
                simon_turn    = 1'b1;
                simon_pressed = 1'b1;
                simon_num     = w_sym;
            end
            default: begin
            end
        endcase
    end

endmodule
